// File: rtl/proc_io_pkg.sv
// Shared constants for the proc_fx IO controller: status word layout and error flag bits.
package proc_io_pkg;

    localparam int STAT_FULL_LSB = 0;
    localparam int STAT_OVAL_LSB = 8;
    localparam int STAT_ERR_BIT  = 15;

    localparam int ERR_UDF = 0;
    localparam int ERR_OVF = 1;

endpackage

// File: rtl/io_out_chan.sv
// One output latch with valid/ready handshake; flags a write that lands on unaccepted data.
module io_out_chan #(
    parameter int NUBITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [NUBITS-1:0] wdata,
    input  logic              ready,
    output logic [NUBITS-1:0] data,
    output logic              valid,
    output logic              ovf
);

    logic [NUBITS-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr) begin
            data_d  = wdata;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // A write coinciding with an accept replaces consumed data, so it is not an overflow.
    assign ovf   = wr & valid_q & ~ready;
    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/proc_io_ctrl.sv
// IO controller beside proc_fx: 1-deep input buffers, latched output channels and a
// read-to-clear status word at the top input address.
module proc_io_ctrl
    import proc_io_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int ABI    = $clog2(NUIOIN),
    parameter int ABO    = $clog2(NUIOOU)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req_in,
    input  logic [ABI-1:0]               cpu_addr_in,
    output logic [NUBITS-1:0]            cpu_io_in,
    input  logic                         cpu_out_en,
    input  logic [ABO-1:0]               cpu_addr_out,
    input  logic [NUBITS-1:0]            cpu_io_out,
    input  logic [(NUIOIN-1)*NUBITS-1:0] in_data,
    input  logic [NUIOIN-2:0]            in_valid,
    output logic [NUIOIN-2:0]            in_ready,
    output logic [(NUIOOU-1)*NUBITS-1:0] out_data,
    output logic [NUIOOU-2:0]            out_valid,
    input  logic [NUIOOU-2:0]            out_ready,
    output logic [1:0]                   err_flags
);

    localparam int NIN  = NUIOIN - 1;
    localparam int NOUT = NUIOOU - 1;
    localparam logic [ABI-1:0] STAT_ADDR = ABI'(NIN);

    if (NUBITS < 16) begin : g_chk_bits
        $error("proc_io_ctrl: NUBITS must be >= 16");
    end
    if (NUIOIN > 8) begin : g_chk_in
        $error("proc_io_ctrl: NUIOIN must be <= 8");
    end
    if (NUIOOU > 8) begin : g_chk_out
        $error("proc_io_ctrl: NUIOOU must be <= 8");
    end

    logic [NUBITS-1:0] in_buf [NIN];
    logic [NIN-1:0]    full;
    logic [NOUT-1:0]   ovf_vec;
    logic [1:0]        err_q, err_d;
    logic [NUBITS-1:0] status;
    logic              stat_rd, udf, ovf;

    // Gating with rst keeps the peripheral stalled for the whole reset window.
    assign in_ready = ~full & {NIN{rst}};

    for (genvar i = 0; i < NIN; i++) begin : g_in
        logic [NUBITS-1:0] data_q;
        logic              full_q;
        logic              pop;

        assign pop = cpu_req_in && (cpu_addr_in == ABI'(i)) && full_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                data_q <= '0;
                full_q <= 1'b0;
            end else if (in_valid[i] && in_ready[i]) begin
                data_q <= in_data[i*NUBITS +: NUBITS];
                full_q <= 1'b1;
            end else if (pop) begin
                full_q <= 1'b0;
            end
        end

        assign in_buf[i] = data_q;
        assign full[i]   = full_q;
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_out
        io_out_chan #(
            .NUBITS(NUBITS)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .wr   (cpu_out_en && (cpu_addr_out == ABO'(j))),
            .wdata(cpu_io_out),
            .ready(out_ready[j]),
            .data (out_data[j*NUBITS +: NUBITS]),
            .valid(out_valid[j]),
            .ovf  (ovf_vec[j])
        );
    end

    assign ovf     = |ovf_vec;
    assign stat_rd = cpu_req_in && (cpu_addr_in == STAT_ADDR);
    assign udf     = cpu_req_in && (cpu_addr_in < STAT_ADDR) && !full[cpu_addr_in];

    always_comb begin
        status                           = '0;
        status[STAT_FULL_LSB +: NIN]     = full;
        status[STAT_OVAL_LSB +: NOUT]    = out_valid;
        status[STAT_ERR_BIT]             = |err_q;
    end

    // Combinational read: the core samples io_in in the same cycle it raises req_in.
    always_comb begin
        cpu_io_in = '0;
        if (cpu_addr_in == STAT_ADDR) begin
            cpu_io_in = status;
        end else if (cpu_addr_in < STAT_ADDR) begin
            cpu_io_in = in_buf[cpu_addr_in];
        end
    end

    // A fresh error in the clearing cycle must survive, so sets are applied last.
    always_comb begin
        err_d = err_q;
        if (stat_rd) begin
            err_d = '0;
        end
        if (udf) begin
            err_d[ERR_UDF] = 1'b1;
        end
        if (ovf) begin
            err_d[ERR_OVF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flags = err_q;

endmodule

// File: tb/tb_proc_io_ctrl.sv
// Self-checking bench for proc_io_ctrl: per-cycle comparison against an array-based model
// plus directed scenarios with literal expectations.
module tb_proc_io_ctrl;

    localparam int NB = 16;
    localparam int NI = 7;
    localparam int NO = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           cpu_req_in;
    logic [2:0]     cpu_addr_in;
    logic [NB-1:0]  cpu_io_in;
    logic           cpu_out_en;
    logic [2:0]     cpu_addr_out;
    logic [NB-1:0]  cpu_io_out;
    logic [NI*NB-1:0] in_data;
    logic [NI-1:0]  in_valid;
    logic [NI-1:0]  in_ready;
    logic [NO*NB-1:0] out_data;
    logic [NO-1:0]  out_valid;
    logic [NO-1:0]  out_ready;
    logic [1:0]     err_flags;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [NB-1:0] m_buf [NI];
    logic          m_full[NI];
    logic [NB-1:0] m_od  [NO];
    logic          m_ov  [NO];
    logic [1:0]    m_err;

    proc_io_ctrl #(
        .NUBITS(16),
        .NUIOIN(8),
        .NUIOOU(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_in  (cpu_req_in),
        .cpu_addr_in (cpu_addr_in),
        .cpu_io_in   (cpu_io_in),
        .cpu_out_en  (cpu_out_en),
        .cpu_addr_out(cpu_addr_out),
        .cpu_io_out  (cpu_io_out),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_flags   (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] m_status();
        logic [NB-1:0] s = '0;
        for (int i = 0; i < NI; i++) s[i] = m_full[i];
        for (int j = 0; j < NO; j++) s[8 + j] = m_ov[j];
        s[15] = (m_err != 2'b00);
        return s;
    endfunction

    task automatic compare_all();
        logic [NB-1:0]    e_rd;
        logic [NI-1:0]    e_rdy;
        logic [NO*NB-1:0] e_od;
        logic [NO-1:0]    e_ov;
        e_rd = (cpu_addr_in == 3'd7) ? m_status() : m_buf[cpu_addr_in];
        for (int i = 0; i < NI; i++) e_rdy[i] = rst && !m_full[i];
        for (int j = 0; j < NO; j++) begin
            e_od[j*NB +: NB] = m_od[j];
            e_ov[j]          = m_ov[j];
        end
        chk("cpu_io_in", 128'(cpu_io_in), 128'(e_rd));
        chk("in_ready", 128'(in_ready), 128'(e_rdy));
        chk("out_data", 128'(out_data), 128'(e_od));
        chk("out_valid", 128'(out_valid), 128'(e_ov));
        chk("err_flags", 128'(err_flags), 128'(m_err));
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    // Advance one clock, updating the model from the inputs held during the cycle.
    task automatic clock();
        logic [NB-1:0] nb [NI];
        logic          nf [NI];
        logic [NB-1:0] nd [NO];
        logic          nv [NO];
        logic          udf, ovf;
        logic [1:0]    ne;
        udf = 1'b0;
        ovf = 1'b0;
        for (int i = 0; i < NI; i++) begin
            nb[i] = m_buf[i];
            nf[i] = m_full[i];
        end
        for (int j = 0; j < NO; j++) begin
            nd[j] = m_od[j];
            nv[j] = m_ov[j];
        end
        ne = m_err;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                nb[i] = '0;
                nf[i] = 1'b0;
            end
            for (int j = 0; j < NO; j++) begin
                nd[j] = '0;
                nv[j] = 1'b0;
            end
            ne = 2'b00;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (in_valid[i] && !m_full[i]) begin
                    nb[i] = in_data[i*NB +: NB];
                    nf[i] = 1'b1;
                end
            end
            if (cpu_req_in && cpu_addr_in < 3'd7) begin
                if (m_full[cpu_addr_in]) nf[cpu_addr_in] = 1'b0;
                else udf = 1'b1;
            end
            for (int j = 0; j < NO; j++) begin
                if (cpu_out_en && cpu_addr_out == 3'(j)) begin
                    if (m_ov[j] && !out_ready[j]) ovf = 1'b1;
                    nd[j] = cpu_io_out;
                    nv[j] = 1'b1;
                end else if (m_ov[j] && out_ready[j]) begin
                    nv[j] = 1'b0;
                end
            end
            if (cpu_req_in && cpu_addr_in == 3'd7) ne = 2'b00;
            ne = ne | {ovf, udf};
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            m_buf[i]  = nb[i];
            m_full[i] = nf[i];
        end
        for (int j = 0; j < NO; j++) begin
            m_od[j] = nd[j];
            m_ov[j] = nv[j];
        end
        m_err = ne;
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        clock();
    endtask

    task automatic idle();
        cpu_req_in   = 1'b0;
        cpu_addr_in  = 3'd0;
        cpu_out_en   = 1'b0;
        cpu_addr_out = 3'd0;
        cpu_io_out   = '0;
        in_data      = '0;
        in_valid     = '0;
        out_ready    = '0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_buf[i]  = '0;
            m_full[i] = 1'b0;
        end
        for (int j = 0; j < NO; j++) begin
            m_od[j] = '0;
            m_ov[j] = 1'b0;
        end
        m_err = 2'b00;
        idle();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        settle();
        chk("reset in_ready", 128'(in_ready), 128'(7'h7F));
        chk("reset out_valid", 128'(out_valid), 128'(7'h00));
        clock();

        // Reset mid-transfer
        in_valid[0] = 1'b1;
        in_data[0*NB +: NB] = 16'h1234;
        cpu_out_en = 1'b1;
        cpu_addr_out = 3'd2;
        cpu_io_out = 16'h00AA;
        cycle();
        idle();
        settle();
        chk("pre-reset out_valid", 128'(out_valid), 128'(7'b0000100));
        chk("pre-reset in_ready", 128'(in_ready), 128'(7'b1111110));
        clock();
        rst = 1'b0;
        cycle();
        cpu_req_in = 1'b1;
        cpu_addr_in = 3'd7;
        settle();
        chk("in reset status", 128'(cpu_io_in), 128'(16'h0000));
        chk("in reset in_ready", 128'(in_ready), 128'(7'h00));
        chk("in reset out_valid", 128'(out_valid), 128'(7'h00));
        clock();
        idle();
        rst = 1'b1;
        settle();
        chk("post reset in_ready", 128'(in_ready), 128'(7'h7F));
        clock();

        // Input flow on channel 3
        in_valid[3] = 1'b1;
        in_data[3*NB +: NB] = 16'h0F0F;
        cycle();
        idle();
        settle();
        chk("ch3 in_ready low", 128'(in_ready[3]), 128'(1'b0));
        clock();
        cpu_req_in = 1'b1;
        cpu_addr_in = 3'd3;
        settle();
        chk("ch3 read", 128'(cpu_io_in), 128'(16'h0F0F));
        clock();
        idle();
        settle();
        chk("ch3 in_ready back", 128'(in_ready[3]), 128'(1'b1));
        clock();

        // Underflow on channel 1
        in_valid[1] = 1'b1;
        in_data[1*NB +: NB] = 16'hBEEF;
        cycle();
        idle();
        cpu_req_in = 1'b1;
        cpu_addr_in = 3'd1;
        cycle();
        settle();
        chk("underflow data", 128'(cpu_io_in), 128'(16'hBEEF));
        clock();
        idle();
        settle();
        chk("underflow flag", 128'(err_flags), 128'(2'b01));
        clock();
        cpu_req_in = 1'b1;
        cpu_addr_in = 3'd7;
        settle();
        chk("status err bit", 128'(cpu_io_in), 128'(16'h8000));
        clock();
        idle();
        settle();
        chk("err cleared", 128'(err_flags), 128'(2'b00));
        clock();

        // Output back-pressure on channel 0
        cpu_out_en = 1'b1;
        cpu_addr_out = 3'd0;
        cpu_io_out = 16'h0011;
        cycle();
        cpu_io_out = 16'h0022;
        cycle();
        idle();
        settle();
        chk("ovf data", 128'(out_data[0 +: NB]), 128'(16'h0022));
        chk("ovf flag", 128'(err_flags), 128'(2'b10));
        chk("ovf valid", 128'(out_valid[0]), 128'(1'b1));
        clock();
        out_ready[0] = 1'b1;
        cycle();
        idle();
        settle();
        chk("accept clears valid", 128'(out_valid[0]), 128'(1'b0));
        clock();
        cpu_req_in = 1'b1;
        cpu_addr_in = 3'd7;
        cycle();
        idle();

        // Write coinciding with accept on channel 4
        cpu_out_en = 1'b1;
        cpu_addr_out = 3'd4;
        cpu_io_out = 16'h1111;
        cycle();
        cpu_io_out = 16'h7777;
        out_ready[4] = 1'b1;
        cycle();
        idle();
        settle();
        chk("wr+accept data", 128'(out_data[4*NB +: NB]), 128'(16'h7777));
        chk("wr+accept valid", 128'(out_valid[4]), 128'(1'b1));
        chk("wr+accept no ovf", 128'(err_flags), 128'(2'b00));
        clock();

        // Status layout: full = 0b0000101, out_valid[6] only
        in_valid = 7'b0000101;
        in_data[0*NB +: NB] = 16'h0001;
        in_data[2*NB +: NB] = 16'h0003;
        out_ready[4] = 1'b1;
        cpu_out_en = 1'b1;
        cpu_addr_out = 3'd6;
        cpu_io_out = 16'h0066;
        cycle();
        idle();
        cpu_req_in = 1'b1;
        cpu_addr_in = 3'd7;
        settle();
        chk("status layout", 128'(cpu_io_in), 128'(16'h4005));
        clock();
        idle();

        // Reserved output address is ignored
        cpu_out_en = 1'b1;
        cpu_addr_out = 3'd7;
        cpu_io_out = 16'h5555;
        cycle();
        idle();
        settle();
        chk("reserved write ignored", 128'(out_valid), 128'(7'b1000000));
        chk("reserved write no flag", 128'(err_flags), 128'(2'b00));
        clock();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 49) != 0);
            cpu_req_in   = 1'($urandom_range(0, 1));
            cpu_addr_in  = 3'($urandom_range(0, 7));
            cpu_out_en   = 1'($urandom_range(0, 1));
            cpu_addr_out = 3'($urandom_range(0, 7));
            cpu_io_out   = 16'($urandom);
            for (int i = 0; i < NI; i++) in_data[i*NB +: NB] = 16'($urandom);
            in_valid     = 7'($urandom);
            out_ready    = 7'($urandom);
            cycle();
        end
        rst = 1'b1;
        idle();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
